// File: rtl/diff_in_quad_decoder.sv
// ---------------------------------------------------------------------------
// diff_in_quad_decoder
//
// Quadrature decoder for the differential-input channels. It takes the
// debounced A/B/index lines, keeps a 32-bit signed 4x position count, an
// index-latched copy of that position and a saturating illegal-transition
// error count. Everything is exposed on the FPGA-2 address/data bus through
// a registered read mux with an avail flag.
//
// Ports
//   xclk                 system clock
//   reset                asynchronous, active-low reset
//   read_qualified       bus read strobe, one xclk wide
//   write_qualified      bus write strobe, one xclk wide
//   ab[7:0]              address bus
//   db_in[15:0]          write data
//   enc_a, enc_b         debounced quadrature inputs, synchronous to xclk
//   enc_index            debounced index input, synchronous to xclk
//   db_out_ENC[15:0]     registered read data
//   data_from_ENC_avail  high when db_out_ENC holds data from a matched address
//
// Register map
//   ADDR_POS_LO  position[15:0], snapshots position[31:16]
//   ADDR_POS_HI  snapshotted position[31:16]
//   ADDR_IDX_LO  idx_pos[15:0], snapshots idx_pos[31:16]
//   ADDR_IDX_HI  snapshotted idx_pos[31:16]
//   ADDR_STATUS  {err_cnt, 4'h0, idx_seen, err_sticky, dir, primed}
//   ADDR_CTRL    write: bit0 CLR_POS, bit1 CLR_ERR, bit2 IDX_ZERO,
//                       bit3 INVERT, bit4 CLR_IDX_SEEN
//                read:  INVERT at bit3, IDX_ZERO at bit2, all else 0
// ---------------------------------------------------------------------------
module diff_in_quad_decoder #(
   parameter logic [7:0] ADDR_POS_LO = 8'h60,
   parameter logic [7:0] ADDR_POS_HI = 8'h61,
   parameter logic [7:0] ADDR_IDX_LO = 8'h62,
   parameter logic [7:0] ADDR_IDX_HI = 8'h63,
   parameter logic [7:0] ADDR_STATUS = 8'h64,
   parameter logic [7:0] ADDR_CTRL   = 8'h65
) (
   input  logic        xclk,
   input  logic        reset,
   input  logic        read_qualified,
   input  logic        write_qualified,
   input  logic [7:0]  ab,
   input  logic [15:0] db_in,
   input  logic        enc_a,
   input  logic        enc_b,
   input  logic        enc_index,
   output logic [15:0] db_out_ENC,
   output logic        data_from_ENC_avail
);

   // Decoder state
   logic [1:0]  prev_ab;
   logic        prev_idx;
   logic        primed;

   // Counters and flags
   logic [31:0] position;
   logic [31:0] idx_pos;
   logic [15:0] pos_hi_shadow;
   logic [15:0] idx_hi_shadow;
   logic [7:0]  err_cnt;
   logic        err_sticky;
   logic        dir;
   logic        idx_seen;

   // Stored control bits
   logic        idx_zero;
   logic        invert;

   // Combinational decode results
   logic [1:0]  cur_pos;
   logic [1:0]  prev_pos;
   logic [1:0]  delta;
   logic        step_up;
   logic        step_dn;
   logic        illegal;
   logic        idx_rise;
   logic [31:0] pos_stepped;
   logic        ctrl_wr;
   logic        clr_pos;
   logic        clr_err;
   logic        clr_idx_seen;
   logic [15:0] rd_data;
   logic        rd_hit;

   // Gray code 00,01,11,10 maps to phase 0,1,2,3 as {a, a^b}; the phase
   // difference then tells forward (1), reverse (3), none (0), illegal (2).
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      cur_pos      = {enc_a, enc_a ^ enc_b};
      prev_pos     = {prev_ab[1], prev_ab[1] ^ prev_ab[0]};
      delta        = cur_pos - prev_pos;
      step_up      = 1'b0;
      step_dn      = 1'b0;
      illegal      = 1'b0;
      if (primed) begin
         case (delta)
            2'd1:    begin step_up = ~invert; step_dn =  invert; end
            2'd3:    begin step_up =  invert; step_dn = ~invert; end
            2'd2:    illegal = 1'b1;
            default: ;
         endcase
      end

      pos_stepped = position;
      if (step_up)
         pos_stepped = position + 32'd1;
      else if (step_dn)
         pos_stepped = position - 32'd1;

      idx_rise     = primed & enc_index & ~prev_idx;

      ctrl_wr      = write_qualified && (ab == ADDR_CTRL);
      clr_pos      = ctrl_wr & db_in[0];
      clr_err      = ctrl_wr & db_in[1];
      clr_idx_seen = ctrl_wr & db_in[4];
   end

   // Decoder, position, index latch, error tracking and control bits
   always_ff @(posedge xclk or negedge reset) begin
      if (!reset) begin
         prev_ab    <= 2'b00;
         prev_idx   <= 1'b0;
         primed     <= 1'b0;
         position   <= 32'h0;
         idx_pos    <= 32'h0;
         err_cnt    <= 8'h00;
         err_sticky <= 1'b0;
         dir        <= 1'b0;
         idx_seen   <= 1'b0;
         idx_zero   <= 1'b0;
         invert     <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so
         // every register here sees the pre-edge value of every other one.
         prev_ab  <= {enc_a, enc_b};
         prev_idx <= enc_index;
         primed   <= 1'b1;

         if (step_up)
            dir <= 1'b1;
         else if (step_dn)
            dir <= 1'b0;

         // CLR_POS beats index zeroing, which beats the step
         if (clr_pos)
            position <= 32'h0;
         else if (idx_rise && idx_zero)
            position <= 32'h0;
         else
            position <= pos_stepped;

         // The latch captures the stepped value even if the count is cleared
         if (idx_rise)
            idx_pos <= pos_stepped;

         // A same-cycle index event is not lost to a clear request
         if (idx_rise)
            idx_seen <= 1'b1;
         else if (clr_idx_seen)
            idx_seen <= 1'b0;

         if (clr_err) begin
            err_cnt    <= 8'h00;
            err_sticky <= 1'b0;
         end else if (illegal) begin
            err_sticky <= 1'b1;
            if (err_cnt != 8'hFF)
               err_cnt <= err_cnt + 8'd1;
         end

         if (ctrl_wr) begin
            idx_zero <= db_in[2];
            invert   <= db_in[3];
         end
      end
   end

   // Read mux
   always_comb begin
      rd_data = 16'hFFFF;
      rd_hit  = 1'b1;
      case (ab)
         ADDR_POS_LO: rd_data = position[15:0];
         ADDR_POS_HI: rd_data = pos_hi_shadow;
         ADDR_IDX_LO: rd_data = idx_pos[15:0];
         ADDR_IDX_HI: rd_data = idx_hi_shadow;
         ADDR_STATUS: rd_data = {err_cnt, 4'h0, idx_seen, err_sticky, dir, primed};
         ADDR_CTRL:   rd_data = {12'h000, invert, idx_zero, 2'b00};
         default: begin
            rd_data = 16'hFFFF;
            rd_hit  = 1'b0;
         end
      endcase
   end

   // Registered read port; LO reads freeze the matching upper half so a
   // following HI read is coherent with it even if the count moves.
   always_ff @(posedge xclk or negedge reset) begin
      if (!reset) begin
         db_out_ENC          <= 16'h0000;
         data_from_ENC_avail <= 1'b0;
         pos_hi_shadow       <= 16'h0000;
         idx_hi_shadow       <= 16'h0000;
      end else if (read_qualified) begin
         db_out_ENC          <= rd_data;
         data_from_ENC_avail <= rd_hit;
         if (ab == ADDR_POS_LO)
            pos_hi_shadow <= position[31:16];
         if (ab == ADDR_IDX_LO)
            idx_hi_shadow <= idx_pos[31:16];
      end
   end

endmodule

// File: tb/tb_diff_in_quad_decoder.sv
// ---------------------------------------------------------------------------
// tb_diff_in_quad_decoder
//
// Self-checking bench for diff_in_quad_decoder. Stimulus is applied on the
// falling edge; every read pushes its expected data/avail (from a small
// behavioural model of the decoder) into a queue, and a monitor pops and
// compares one xclk later, 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_diff_in_quad_decoder;

   localparam logic [7:0] A_POS_LO = 8'h60;
   localparam logic [7:0] A_POS_HI = 8'h61;
   localparam logic [7:0] A_IDX_LO = 8'h62;
   localparam logic [7:0] A_IDX_HI = 8'h63;
   localparam logic [7:0] A_STATUS = 8'h64;
   localparam logic [7:0] A_CTRL   = 8'h65;

   logic        xclk;
   logic        reset;
   logic        read_qualified;
   logic        write_qualified;
   logic [7:0]  ab;
   logic [15:0] db_in;
   logic        enc_a;
   logic        enc_b;
   logic        enc_index;
   logic [15:0] db_out_ENC;
   logic        data_from_ENC_avail;

   diff_in_quad_decoder dut (
      .xclk                (xclk),
      .reset               (reset),
      .read_qualified      (read_qualified),
      .write_qualified     (write_qualified),
      .ab                  (ab),
      .db_in               (db_in),
      .enc_a               (enc_a),
      .enc_b               (enc_b),
      .enc_index           (enc_index),
      .db_out_ENC          (db_out_ENC),
      .data_from_ENC_avail (data_from_ENC_avail)
   );

   initial xclk = 1'b0;
   always #5 xclk = ~xclk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Scoreboard: {avail, data} per outstanding read
   string       tag_q[$];
   logic [16:0] exp_q[$];

   // Behavioural model
   logic [1:0]  m_ph;          // quadrature phase 0..3
   logic [31:0] m_pos;
   logic [31:0] m_idx_pos;
   logic [15:0] m_pos_sh;
   logic [15:0] m_idx_sh;
   logic [7:0]  m_err;
   logic        m_sticky;
   logic        m_dir;
   logic        m_seen;
   logic        m_primed;
   logic        m_idx_zero;
   logic        m_inv;

   task automatic model_reset();
      m_pos = 0; m_idx_pos = 0; m_pos_sh = 0; m_idx_sh = 0;
      m_err = 0; m_sticky = 0; m_dir = 0; m_seen = 0; m_primed = 0;
      m_idx_zero = 0; m_inv = 0;
   endtask

   task automatic drive_phase();
      enc_a = m_ph[1];
      enc_b = m_ph[1] ^ m_ph[0];
   endtask

   // All set_* tasks act within the current low phase of xclk; call the
   // read first, then step/illegal/index, then write, to match edge order.
   task automatic set_read(input string tag, input logic [7:0] a);
      logic [15:0] d;
      logic        hit;
      hit = 1'b1;
      case (a)
         A_POS_LO: begin d = m_pos[15:0]; m_pos_sh = m_pos[31:16]; end
         A_POS_HI: d = m_pos_sh;
         A_IDX_LO: begin d = m_idx_pos[15:0]; m_idx_sh = m_idx_pos[31:16]; end
         A_IDX_HI: d = m_idx_sh;
         A_STATUS: d = {m_err, 4'h0, m_seen, m_sticky, m_dir, m_primed};
         A_CTRL:   d = {12'h000, m_inv, m_idx_zero, 2'b00};
         default:  begin d = 16'hFFFF; hit = 1'b0; end
      endcase
      ab = a;
      read_qualified = 1'b1;
      tag_q.push_back(tag);
      exp_q.push_back({hit, d});
   endtask

   task automatic set_step(input logic fwd);
      m_ph = fwd ? m_ph + 2'd1 : m_ph - 2'd1;
      drive_phase();
      if (fwd ^ m_inv) begin m_pos = m_pos + 1; m_dir = 1'b1; end
      else             begin m_pos = m_pos - 1; m_dir = 1'b0; end
   endtask

   task automatic set_illegal();
      m_ph = m_ph + 2'd2;
      drive_phase();
      m_sticky = 1'b1;
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
   endtask

   task automatic set_index(input logic v);
      if (v && !enc_index) begin
         m_idx_pos = m_pos;
         m_seen    = 1'b1;
         if (m_idx_zero) m_pos = 0;
      end
      enc_index = v;
   endtask

   task automatic set_write(input logic [15:0] d);
      ab = A_CTRL;
      db_in = d;
      write_qualified = 1'b1;
      if (d[0]) m_pos = 0;
      if (d[1]) begin m_err = 0; m_sticky = 0; end
      if (d[4]) m_seen = 1'b0;
      m_idx_zero = d[2];
      m_inv      = d[3];
   endtask

   task automatic tick();
      @(posedge xclk);
      m_primed = 1'b1;
      @(negedge xclk);
      read_qualified  = 1'b0;
      write_qualified = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [7:0] a);
      set_read(tag, a);
      tick();
   endtask

   task automatic wr(input logic [15:0] d);
      set_write(d);
      tick();
   endtask

   // Monitor: compare each read one edge after it is sampled
   string       mon_tag;
   logic [16:0] mon_exp;
   always @(posedge xclk) begin
      if (reset && read_qualified) begin
         #1;
         if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
         end else begin
            mon_tag = tag_q.pop_front();
            mon_exp = exp_q.pop_front();
            check({mon_tag, "_data"},  {16'h0, db_out_ENC}, {16'h0, mon_exp[15:0]});
            check({mon_tag, "_avail"}, {31'h0, data_from_ENC_avail}, {31'h0, mon_exp[16]});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0; read_qualified = 1'b0; write_qualified = 1'b0;
      ab = 8'h00; db_in = 16'h0000; enc_index = 1'b0;
      m_ph = 2'd2;                 // AB = 11
      drive_phase();
      model_reset();
      #1;
      check("rst_data",  {16'h0, db_out_ENC}, 32'h0);
      check("rst_avail", {31'h0, data_from_ENC_avail}, 32'h0);
      @(negedge xclk);
      @(negedge xclk);
      reset = 1'b1;

      // Reset state and priming with AB held at 11
      rd("idx_hi_noprior", A_IDX_HI);   // also the cycle that primes
      tick(); tick();
      rd("status_after_reset", A_STATUS);
      rd("pos_lo_zero", A_POS_LO);
      rd("pos_hi_zero", A_POS_HI);

      // 8 forward steps
      for (int i = 0; i < 8; i++) begin set_step(1'b1); tick(); end
      rd("fwd8_lo", A_POS_LO);
      rd("fwd8_hi", A_POS_HI);
      rd("fwd8_status", A_STATUS);

      // Reverse from 0 wraps to FFFFFFFF; shadow keeps HI coherent
      wr(16'h0001);
      set_step(1'b0); tick();
      rd("rev_lo", A_POS_LO);
      rd("rev_hi", A_POS_HI);
      rd("rev_lo2", A_POS_LO);
      set_step(1'b0); tick();
      rd("rev_hi_shadow", A_POS_HI);
      wr(16'h0001);
      set_read("same_edge_lo", A_POS_LO); set_step(1'b0); tick();
      rd("same_edge_hi", A_POS_HI);
      rd("same_edge_lo_after", A_POS_LO);

      // INVERT: physical forward counts down, DIR=0; new setting lags one edge
      wr(16'h0009);
      rd("ctrl_invert", A_CTRL);
      for (int i = 0; i < 3; i++) begin set_step(1'b1); tick(); end
      rd("inv_lo", A_POS_LO);
      rd("inv_status", A_STATUS);
      wr(16'h0000);
      set_step(1'b1); tick();
      rd("uninv_status", A_STATUS);

      // Illegal transitions and saturation
      for (int i = 0; i < 3; i++) begin set_illegal(); tick(); end
      rd("err3_status", A_STATUS);
      for (int i = 0; i < 297; i++) begin set_illegal(); tick(); end
      rd("err_sat_status", A_STATUS);
      rd("err_pos_unchanged", A_POS_LO);
      set_illegal(); set_write(16'h0002); tick();
      rd("clr_err_status", A_STATUS);

      // Index zeroing with a same-cycle step
      wr(16'h0001);
      for (int i = 0; i < 5; i++) begin set_step(1'b1); tick(); end
      wr(16'h0004);
      set_step(1'b1); set_index(1'b1); tick();
      rd("idx_lo", A_IDX_LO);
      rd("idx_hi", A_IDX_HI);
      rd("idx_pos_zeroed", A_POS_LO);
      rd("idx_status", A_STATUS);
      set_index(1'b0); tick();
      for (int i = 0; i < 3; i++) begin set_step(1'b1); tick(); end
      set_step(1'b1); set_index(1'b1); set_write(16'h0005); tick();
      rd("idx_clr_lo", A_IDX_LO);
      rd("idx_clr_pos", A_POS_LO);
      set_index(1'b0); tick();
      wr(16'h0010);
      rd("seen_cleared_status", A_STATUS);
      rd("ctrl_cleared", A_CTRL);

      // Unmapped address, then outputs hold with no read
      rd("unmapped", 8'h7F);
      tick();
      check("hold_data",  {16'h0, db_out_ENC}, 32'h0000FFFF);
      check("hold_avail", {31'h0, data_from_ENC_avail}, 32'h0);

      // Mid-operation asynchronous reset
      set_step(1'b1); tick();
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check("midrst_data",  {16'h0, db_out_ENC}, 32'h0);
      check("midrst_avail", {31'h0, data_from_ENC_avail}, 32'h0);
      @(negedge xclk);
      reset = 1'b1;
      rd("midrst_unprimed", A_STATUS);
      rd("midrst_primed", A_STATUS);
      rd("midrst_pos", A_POS_LO);

      tick();
      check("sb_drain", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
